jtkunio_paldma: RTL and testbench
=================================

JTKUNIO_PALDMA -- requirements
Module: jtkunio_paldma

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter AW, default 9, SHALL set the palette address width; a full copy is 2^AW bytes.
REQ-003 Parameter SRC_BASE, default 0, SHALL set the source start address; its width is 22 bits.
REQ-004 Parameter VB_ONLY, default 1, SHALL when set allow fetches to start only while LVBL is low.
REQ-005 Ports (clock and reset first), as name, direction, width, meaning:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- LVBL  in  1  vertical blank, active low
- start  in  1  copy request pulse
- busy  out  1  copy in progress
- done  out  1  one-cycle pulse at copy end
- src_cs  out  1  source read request
- src_addr  out  22  source byte address
- src_data  in  8  source read data
- src_ok  in  1  source data valid
- cpu_cs  in  1  CPU palette select
- cpu_wrn  in  1  CPU write strobe, active low
- cpu_addr  in  AW  CPU palette address
- cpu_dout  in  8  CPU write data
- pal_we  out  1  palette RAM write enable
- pal_addr  out  AW  palette RAM address
- pal_din  out  8  palette RAM write data

Function
REQ-006 The FSM SHALL have exactly three states: IDLE, FETCH and WRITE.
REQ-007 In IDLE, a start sampled high SHALL clear the byte counter cnt to 0, set busy, and enter FETCH on the next cycle.
REQ-008 In FETCH:
- src_cs SHALL be 1 and src_addr SHALL equal SRC_BASE+cnt.
- With VB_ONLY=1 and LVBL=1, src_cs SHALL be 0 and the FSM SHALL wait in FETCH.
REQ-009 src_ok SHALL be honoured only in FETCH while src_cs=1; in that cycle src_data SHALL be latched and the FSM SHALL enter WRITE.
REQ-010 src_ok seen outside that condition SHALL be ignored.
REQ-011 Once a fetch has completed, the write SHALL proceed even if LVBL has risen.
REQ-012 In WRITE with no CPU write pending:
- pal_we=1, pal_addr=cnt, pal_din=latched byte.
- If cnt=2^AW-1, the next cycle SHALL be IDLE with busy=0 and done=1 for one cycle.
- Otherwise cnt SHALL increment by 1 and the FSM SHALL return to FETCH.
REQ-013 A CPU write (cpu_cs=1 and cpu_wrn=0) SHALL drive pal_we=1, pal_addr=cpu_addr and pal_din=cpu_dout combinationally, in any state.
REQ-014 A CPU write SHALL take priority over the DMA; the DMA SHALL stay in WRITE and retry in the next cycle, losing no data.
REQ-015 The minimum cost SHALL be 2 cycles per byte, so a full AW=9 copy with zero-wait src_ok SHALL take 1024 cycles from the first FETCH to the last write.
REQ-016 start while busy=1 SHALL be ignored.
REQ-017 start in the same cycle as done SHALL be ignored, because done is produced in IDLE after the completion cycle.
REQ-018 cnt SHALL be AW bits wide; copy end SHALL be detected on the last address, never by counter overflow.
REQ-019 src_addr SHALL be the 22-bit sum SHALL be computed modulo 2^22.
REQ-020 When no write is active, pal_we SHALL be 0 and pal_addr/pal_din SHALL hold their last DMA values.

Reset
REQ-021 While rst_n=0 the FSM SHALL go to IDLE and drive busy=0, done=0, src_cs=0, src_addr=SRC_BASE, cnt=0 and latched byte=0.
REQ-022 While rst_n=0 the DMA SHALL issue no palette write; the CPU write path of REQ-013 SHALL remain active.
REQ-023 A reset during a copy SHALL abort it without a done pulse; bytes already written SHALL stay written.

Verification
REQ-024 Full copy: source byte i = i^8'h5A, src_ok one cycle after src_cs, LVBL=0, start pulse -> 512 writes to addresses 0..511 in order, done at the expected cycle, busy low afterwards.
REQ-025 CPU collision: CPU writes 8'hA5 to address 300 in the same cycle as DMA WRITE of address 7 -> RAM[300]=A5 in that cycle, DMA writes address 7 in the next cycle, final RAM[7]=7^5A.
REQ-026 VB gating: LVBL=1 at start -> src_cs stays 0; LVBL falls -> fetch begins; LVBL rises mid-fetch -> pending write completes and the next fetch stalls.
REQ-027 Mid-copy reset: rst_n=0 after 100 bytes -> busy=0, no done, no further writes; a new start copies from address 0.
REQ-028 Ignored start: start re-pulsed during a copy and stray src_ok in IDLE -> no restart, no extra writes, exactly one done.

Source files
------------

// File: rtl/jtkunio_paldma.sv
// Palette DMA: copies 2^AW bytes from a 22-bit source bus into palette RAM,
// one byte per FETCH/WRITE pair, with CPU writes to the palette taking priority.
//
// state | meaning
// IDLE  | waiting for start; done pulses here for one cycle after a copy
// FETCH | source read of byte cnt (gated by LVBL when VB_ONLY)
// WRITE | writing latched byte to palette address cnt, retried on CPU collision
module jtkunio_paldma #(
    parameter int          AW       = 9,
    parameter logic [21:0] SRC_BASE = 22'd0,
    parameter bit          VB_ONLY  = 1'b1
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          LVBL,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          src_cs,
    output logic [21:0]   src_addr,
    input  logic [7:0]    src_data,
    input  logic          src_ok,
    input  logic          cpu_cs,
    input  logic          cpu_wrn,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_dout,
    output logic          pal_we,
    output logic [AW-1:0] pal_addr,
    output logic [7:0]    pal_din
);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] cnt;
    logic [7:0]    dbyte;
    logic          done_r;
    logic [AW-1:0] hold_addr;
    logic [7:0]    hold_din;
    logic          cpu_wr, fetch_en, fetch_ok, dma_wr, last, accept;

    assign cpu_wr   = cpu_cs & ~cpu_wrn;
    assign fetch_en = (state == FETCH) && !(VB_ONLY && LVBL);
    assign fetch_ok = fetch_en && src_ok;
    assign dma_wr   = (state == WRITE) && !cpu_wr;
    assign last     = (cnt == {AW{1'b1}});
    // done_r is only high in the IDLE cycle right after completion, so a start
    // arriving with it is dropped
    assign accept   = (state == IDLE) && start && !done_r;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept)   state_nx = FETCH;
            FETCH:   if (fetch_ok) state_nx = WRITE;
            WRITE:   if (!cpu_wr)  state_nx = last ? IDLE : FETCH;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt       <= '0;
            dbyte     <= '0;
            done_r    <= 1'b0;
            hold_addr <= '0;
            hold_din  <= '0;
        end else begin
            done_r <= dma_wr && last;
            if (accept)   cnt   <= '0;
            if (fetch_ok) dbyte <= src_data;
            if (dma_wr) begin
                hold_addr <= cnt;
                hold_din  <= dbyte;
                if (!last) cnt <= cnt + AW'(1);
            end
        end
    end

    // Reset masks all DMA-side outputs; the CPU write path stays live
    always_comb begin
        busy     = rst_n && (state != IDLE);
        done     = rst_n && done_r;
        src_cs   = rst_n && fetch_en;
        src_addr = rst_n ? SRC_BASE + 22'(cnt) : SRC_BASE;
        pal_we   = 1'b0;
        pal_addr = hold_addr;
        pal_din  = hold_din;
        if (cpu_wr) begin
            pal_we   = 1'b1;
            pal_addr = cpu_addr;
            pal_din  = cpu_dout;
        end else if (rst_n && state == WRITE) begin
            pal_we   = 1'b1;
            pal_addr = cnt;
            pal_din  = dbyte;
        end
    end

endmodule

// File: tb/tb_jtkunio_paldma.sv
// Bench for jtkunio_paldma: source memory and write log modelled at the
// transaction level, expected timing derived from per-byte cycle cost.
module tb_jtkunio_paldma;
    localparam int          AW = 9;
    localparam int          N  = 1 << AW;
    localparam logic [21:0] SB = 22'h3FFF80;

    logic          clk = 0, rst_n = 0, LVBL = 0, start = 0;
    logic          busy, done, src_cs, src_ok, pal_we;
    logic [21:0]   src_addr, src_off;
    logic [7:0]    src_data;
    logic          cpu_cs = 0, cpu_wrn = 1;
    logic [AW-1:0] cpu_addr = '0;
    logic [7:0]    cpu_dout = '0;
    logic [AW-1:0] pal_addr;
    logic [7:0]    pal_din;
    logic          stray_ok = 0;

    int lat = 1, run = 0, cyc = 0;
    int checks = 0, errors = 0;
    int w_cyc[$], w_addr[$], w_data[$], d_cyc[$];
    int dma_n = 0, dma_base = 0, cs_cnt = 0, addr_bad = 0;

    jtkunio_paldma #(.AW(AW), .SRC_BASE(SB), .VB_ONLY(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .LVBL(LVBL), .start(start),
        .busy(busy), .done(done), .src_cs(src_cs), .src_addr(src_addr),
        .src_data(src_data), .src_ok(src_ok),
        .cpu_cs(cpu_cs), .cpu_wrn(cpu_wrn), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout),
        .pal_we(pal_we), .pal_addr(pal_addr), .pal_din(pal_din)
    );

    always #5 clk = ~clk;

    // Source memory: byte at offset i is i^5A, ready lat cycles after src_cs rises
    assign src_off  = src_addr - SB;
    assign src_data = src_off[7:0] ^ 8'h5A;
    assign src_ok   = (src_cs && run >= lat) || stray_ok;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        run <= src_cs ? run + 1 : 0;
    end

    always @(negedge clk) begin
        if (pal_we) begin
            w_cyc.push_back(cyc);
            w_addr.push_back(int'(pal_addr));
            w_data.push_back(int'(pal_din));
            if (!(cpu_cs && !cpu_wrn)) dma_n++;
        end
        if (done) d_cyc.push_back(cyc);
        if (src_cs) begin
            cs_cnt++;
            if (src_addr !== SB + 22'(dma_n - dma_base)) addr_bad++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_logs();
        w_cyc.delete(); w_addr.delete(); w_data.delete(); d_cyc.delete();
        dma_base = dma_n;
    endtask

    task automatic pulse_start(output int c_s);
        c_s = cyc;
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && d_cyc.size() == 0; n++) tick(1);
    endtask

    task automatic test_reset();
        rst_n = 0;
        tick(3);
        @(negedge clk);
        checks++;
        if ({busy, done, src_cs, pal_we} !== 4'b0) begin
            errors++; $display("FAIL reset_outs got %b want 0000", {busy, done, src_cs, pal_we});
        end
        checks++;
        if (src_addr !== SB) begin
            errors++; $display("FAIL reset_src_addr got %h want %h", src_addr, SB);
        end
        cpu_cs = 1; cpu_wrn = 0; cpu_addr = AW'(9'h155); cpu_dout = 8'h3C;
        #1;
        checks++;
        if (pal_we !== 1'b1 || pal_addr !== AW'(9'h155) || pal_din !== 8'h3C) begin
            errors++; $display("FAIL reset_cpu_write got we=%b a=%h d=%h want 1 155 3c", pal_we, pal_addr, pal_din);
        end
        cpu_cs = 0; cpu_wrn = 1;
        tick(1);
        rst_n = 1;
        tick(2);
        @(negedge clk);
        checks++;
        if ({busy, done, src_cs, pal_we} !== 4'b0 || pal_addr !== '0 || pal_din !== 8'h00) begin
            errors++; $display("FAIL post_reset got %b a=%h d=%h want 0000 0 0", {busy, done, src_cs, pal_we}, pal_addr, pal_din);
        end
    endtask

    task automatic test_full_copy(input int l);
        int c_s, ab0, exp_cyc;
        lat = l; LVBL = 0;
        tick(1);
        clear_logs();
        ab0 = addr_bad;
        pulse_start(c_s);
        wait_done(N * (2 + l) + 100);
        tick(3);
        @(negedge clk);
        checks++;
        if (d_cyc.size() != 1 || d_cyc[0] != c_s + 1 + N * (2 + l)) begin
            errors++; $display("FAIL copy_done lat=%0d got n=%0d want one at %0d", l, d_cyc.size(), c_s + 1 + N * (2 + l));
        end
        checks++;
        if (w_cyc.size() != N) begin
            errors++; $display("FAIL copy_count lat=%0d got %0d want %0d", l, w_cyc.size(), N);
        end
        for (int i = 0; i < N && i < w_cyc.size(); i++) begin
            exp_cyc = c_s + 2 + l + i * (2 + l);
            checks++;
            if (w_addr[i] != i || w_data[i] != ((i & 255) ^ 'h5A) || w_cyc[i] != exp_cyc) begin
                errors++; $display("FAIL copy_write[%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                                   i, w_addr[i], w_data[i], w_cyc[i], i, (i & 255) ^ 'h5A, exp_cyc);
            end
        end
        checks++;
        if (busy !== 1'b0 || pal_we !== 1'b0 || pal_addr !== AW'(N - 1) || pal_din !== 8'hA5) begin
            errors++; $display("FAIL copy_idle got b=%b we=%b a=%h d=%h want 0 0 1ff a5", busy, pal_we, pal_addr, pal_din);
        end
        checks++;
        if (addr_bad != ab0) begin
            errors++; $display("FAIL copy_src_addr got %0d bad want 0", addr_bad - ab0);
        end
    endtask

    task automatic test_cpu_collision();
        int c_s, ea, ed, ec, k;
        int ram[N];
        lat = 1; LVBL = 0;
        tick(1);
        clear_logs();
        pulse_start(c_s);
        wait_until(c_s + 24);
        cpu_cs = 1; cpu_wrn = 0; cpu_addr = AW'(300); cpu_dout = 8'hA5;
        @(negedge clk);
        checks++;
        if (pal_we !== 1'b1 || pal_addr !== AW'(300) || pal_din !== 8'hA5) begin
            errors++; $display("FAIL coll_cpu got we=%b a=%0d d=%h want 1 300 a5", pal_we, pal_addr, pal_din);
        end
        tick(1);
        cpu_cs = 0; cpu_wrn = 1;
        @(negedge clk);
        checks++;
        if (pal_we !== 1'b1 || pal_addr !== AW'(7) || pal_din !== 8'h5D) begin
            errors++; $display("FAIL coll_retry got we=%b a=%0d d=%h want 1 7 5d", pal_we, pal_addr, pal_din);
        end
        wait_done(3 * N + 100);
        tick(3);
        checks++;
        if (w_cyc.size() != N + 1 || d_cyc.size() != 1 || d_cyc[0] != c_s + 2 + 3 * N) begin
            errors++; $display("FAIL coll_totals got w=%0d d=%0d want %0d writes, done at %0d", w_cyc.size(), d_cyc.size(), N + 1, c_s + 2 + 3 * N);
        end
        for (int j = 0; j < N + 1 && j < w_cyc.size(); j++) begin
            if (j < 7)       begin k = j;     ea = k;   ed = (k & 255) ^ 'h5A; ec = c_s + 3 + 3 * k; end
            else if (j == 7) begin k = 0;     ea = 300; ed = 'hA5;             ec = c_s + 24;      end
            else             begin k = j - 1; ea = k;   ed = (k & 255) ^ 'h5A; ec = c_s + 4 + 3 * k; end
            ram[w_addr[j]] = w_data[j];
            checks++;
            if (w_addr[j] != ea || w_data[j] != ed || w_cyc[j] != ec) begin
                errors++; $display("FAIL coll_write[%0d] got a=%0d d=%h c=%0d want a=%0d d=%h c=%0d",
                                   j, w_addr[j], w_data[j], w_cyc[j], ea, ed, ec);
            end
        end
        checks++;
        if (ram[7] != 'h5D) begin
            errors++; $display("FAIL coll_ram7 got %h want 5d", ram[7]);
        end
    endtask

    task automatic test_vb_gating();
        int c_s, cs0, l0, ab0;
        lat = 1; LVBL = 1;
        tick(1);
        clear_logs();
        cs0 = cs_cnt; ab0 = addr_bad;
        pulse_start(c_s);
        tick(20);
        @(negedge clk);
        checks++;
        if (cs_cnt != cs0 || busy !== 1'b1) begin
            errors++; $display("FAIL vb_blocked got cs=%0d busy=%b want 0 1", cs_cnt - cs0, busy);
        end
        tick(1);
        l0 = cyc;
        LVBL = 0;
        @(negedge clk);
        checks++;
        if (src_cs !== 1'b1 || src_addr !== SB) begin
            errors++; $display("FAIL vb_fetch_start got cs=%b a=%h want 1 %h", src_cs, src_addr, SB);
        end
        wait_until(l0 + 2);
        LVBL = 1;
        @(negedge clk);
        checks++;
        if (pal_we !== 1'b1 || pal_addr !== '0 || pal_din !== 8'h5A || src_cs !== 1'b0) begin
            errors++; $display("FAIL vb_write_completes got we=%b a=%h d=%h cs=%b want 1 0 5a 0", pal_we, pal_addr, pal_din, src_cs);
        end
        tick(15);
        @(negedge clk);
        checks++;
        if (w_cyc.size() != 1 || src_cs !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL vb_stall got w=%0d cs=%b busy=%b want 1 0 1", w_cyc.size(), src_cs, busy);
        end
        tick(1);
        lat = $urandom_range(0, 2);
        for (int n = 0; n < 30000 && d_cyc.size() == 0; n++) begin
            LVBL = ($urandom_range(0, 3) == 0);
            tick(1);
        end
        LVBL = 0;
        tick(3);
        checks++;
        if (w_cyc.size() != N || d_cyc.size() != 1 || addr_bad != ab0) begin
            errors++; $display("FAIL vb_random got w=%0d d=%0d bad=%0d want %0d 1 0", w_cyc.size(), d_cyc.size(), addr_bad - ab0, N);
        end
        for (int i = 0; i < N && i < w_cyc.size(); i++) begin
            checks++;
            if (w_addr[i] != i || w_data[i] != ((i & 255) ^ 'h5A)) begin
                errors++; $display("FAIL vb_write[%0d] got a=%0d d=%h want a=%0d d=%h", i, w_addr[i], w_data[i], i, (i & 255) ^ 'h5A);
            end
        end
    endtask

    task automatic test_mid_reset();
        int c_s, r;
        lat = 1; LVBL = 0;
        tick(1);
        clear_logs();
        pulse_start(c_s);
        r = $urandom_range(1, 3);
        wait_until(c_s + 300 + r);
        rst_n = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || src_cs !== 1'b0 || pal_we !== 1'b0) begin
            errors++; $display("FAIL rst_abort got b=%b cs=%b we=%b want 0 0 0", busy, src_cs, pal_we);
        end
        tick(4);
        rst_n = 1;
        tick(30);
        @(negedge clk);
        checks++;
        if (w_cyc.size() != 100 || d_cyc.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_aftermath got w=%0d d=%0d b=%b want 100 0 0", w_cyc.size(), d_cyc.size(), busy);
        end
        tick(1);
        clear_logs();
        lat = $urandom_range(0, 2);
        pulse_start(c_s);
        wait_done(N * 4 + 100);
        tick(3);
        checks++;
        if (w_cyc.size() != N || d_cyc.size() != 1 || d_cyc[0] != c_s + 1 + N * (2 + lat)) begin
            errors++; $display("FAIL rst_restart got w=%0d d=%0d want %0d 1", w_cyc.size(), d_cyc.size(), N);
        end
        checks++;
        if (w_cyc.size() < 1 || w_addr[0] != 0 || w_data[0] != 'h5A || w_cyc[0] != c_s + 2 + lat) begin
            errors++; $display("FAIL rst_first_write got n=%0d want a=0 d=5a c=%0d", w_cyc.size(), c_s + 2 + lat);
        end
    endtask

    task automatic test_ignored_start();
        int c_s, d_exp, cs0;
        LVBL = 0;
        tick(1);
        clear_logs();
        stray_ok = 1;
        tick(3);
        stray_ok = 0;
        @(negedge clk);
        checks++;
        if (w_cyc.size() != 0 || busy !== 1'b0) begin
            errors++; $display("FAIL stray_ok got w=%0d b=%b want 0 0", w_cyc.size(), busy);
        end
        tick(1);
        lat = $urandom_range(0, 2);
        pulse_start(c_s);
        d_exp = c_s + 1 + N * (2 + lat);
        for (int k = 0; k < 5; k++) begin
            wait_until(cyc + $urandom_range(5, 150));
            start = 1;
            tick(1);
            start = 0;
        end
        wait_until(d_exp);
        start = 1;
        @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++; $display("FAIL ign_done_cycle got %b want 1 at %0d", done, d_exp);
        end
        tick(1);
        start = 0;
        cs0 = cs_cnt;
        tick(5);
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || cs_cnt != cs0 || d_cyc.size() != 1 || w_cyc.size() != N) begin
            errors++; $display("FAIL ign_start got b=%b cs=%0d d=%0d w=%0d want 0 0 1 %0d", busy, cs_cnt - cs0, d_cyc.size(), w_cyc.size(), N);
        end
        for (int i = 0; i < N && i < w_cyc.size(); i++) begin
            checks++;
            if (w_addr[i] != i || w_cyc[i] != c_s + 2 + lat + i * (2 + lat)) begin
                errors++; $display("FAIL ign_write[%0d] got a=%0d c=%0d want a=%0d c=%0d", i, w_addr[i], w_cyc[i], i, c_s + 2 + lat + i * (2 + lat));
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_copy(1);
        test_full_copy(0);
        test_cpu_collision();
        test_vb_gating();
        test_mid_reset();
        test_ignored_start();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
